onehot_scan_decoder: RTL and testbench

ONEHOT_SCAN_DECODER -- requirements
Module: onehot_scan_decoder

---
 rtl/onehot_dec_pkg.sv | 13 +
 rtl/dwell_timer.sv | 35 +++
 rtl/onehot_scan_decoder.sv | 85 ++++++++
 tb/tb_onehot_scan_decoder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/onehot_dec_pkg.sv
// Shared types and constants for the one-hot scan decoder.
package onehot_dec_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDirect = 2'd1,
    StScan   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: tick_o compares the live count against the live dwell value,
// so a dwell change takes effect on the very next edge.
module dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               tick_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q >= dwell_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with a direct-select mode and a dwell-timed
// scanning mode that walks through all outputs and flags each wrap.
module onehot_scan_decoder
  import onehot_dec_pkg::*;
#(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] out_bits,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  wrap,
  output logic                  active
);

  localparam int unsigned OUT_W = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] SelMax = SEL_W'(OUT_W - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [OUT_W-1:0] out_bits_q, out_bits_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic             scan_run;
  logic             timer_clr;

  always_comb begin
    state_d = StIdle;
    if (en) begin
      state_d = (mode == MODE_SCAN) ? StScan : StDirect;
    end

    // Advancing only happens when already scanning; entry restarts the dwell.
    scan_run  = (state_d == StScan) && (state_q == StScan) && !load;
    timer_clr = (state_d == StScan) && (load || (state_q != StScan));

    cur_sel_d = cur_sel_q;
    wrap_d    = 1'b0;
    if ((state_d != StIdle) && load) begin
      cur_sel_d = sel_in;
    end else if (scan_run && tick) begin
      cur_sel_d = cur_sel_q + SEL_W'(1);
      wrap_d    = (cur_sel_q == SelMax);
    end

    out_bits_d = (state_d == StIdle) ? '0 : (OUT_W'(1) << cur_sel_d);
  end

  dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (timer_clr),
    .en_i   (scan_run),
    .dwell_i(dwell),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_sel_q  <= '0;
      out_bits_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      out_bits_q <= out_bits_d;
      wrap_q     <= wrap_d;
    end
  end

  assign out_bits = out_bits_q;
  assign cur_sel  = cur_sel_q;
  assign wrap     = wrap_q;
  assign active   = (state_q != StIdle);

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed-vector bench: stimulus queues hand-computed expectations per edge,
// a monitor on the falling edge pops and compares them.
module tb_onehot_scan_decoder;

  typedef struct packed {
    logic [3:0] ob;
    logic [1:0] cs;
    logic       w;
    logic       a;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, mode, load;
  logic [1:0] sel_in;
  logic [7:0] dwell;
  logic [3:0] out_bits;
  logic [1:0] cur_sel;
  logic       wrap, active;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder #(
    .SEL_W  (2),
    .DWELL_W(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .load    (load),
    .sel_in  (sel_in),
    .dwell   (dwell),
    .out_bits(out_bits),
    .cur_sel (cur_sel),
    .wrap    (wrap),
    .active  (active)
  );

  // Apply inputs, take one edge, queue what the outputs must be after it.
  task automatic cyc(input logic r, input logic e, input logic m, input logic l,
                     input logic [1:0] s, input logic [7:0] d,
                     input logic [3:0] eo, input logic [1:0] ec,
                     input logic ew, input logic ea);
    exp_t x;
    rst = r; en = e; mode = m; load = l; sel_in = s; dwell = d;
    @(posedge clk);
    x.ob = eo; x.cs = ec; x.w = ew; x.a = ea;
    exp_q.push_back(x);
    #1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_checks++;
        if ({out_bits, cur_sel, wrap, active} !== x) begin
          n_fail++;
          $display("FAIL check%0d t=%0t: got out_bits=%b cur_sel=%0d wrap=%b active=%b, want out_bits=%b cur_sel=%0d wrap=%b active=%b",
                   n_checks, $time, out_bits, cur_sel, wrap, active, x.ob, x.cs, x.w, x.a);
        end
      end
    end
  end

  initial begin : stim
    // Reset dominates en/load.
    cyc(1, 1, 0, 1, 2'd3, 8'd0, 4'b0000, 2'd0, 0, 0);
    cyc(1, 1, 0, 1, 2'd3, 8'd0, 4'b0000, 2'd0, 0, 0);

    // DIRECT decode, then hold without load.
    cyc(0, 1, 0, 1, 2'd0, 8'd0, 4'b0001, 2'd0, 0, 1);
    cyc(0, 1, 0, 1, 2'd1, 8'd0, 4'b0010, 2'd1, 0, 1);
    cyc(0, 1, 0, 1, 2'd2, 8'd0, 4'b0100, 2'd2, 0, 1);
    cyc(0, 1, 0, 1, 2'd3, 8'd0, 4'b1000, 2'd3, 0, 1);
    cyc(0, 1, 0, 0, 2'd0, 8'd0, 4'b1000, 2'd3, 0, 1);
    cyc(0, 1, 0, 1, 2'd0, 8'd0, 4'b0001, 2'd0, 0, 1);

    // SCAN dwell=2: each output lasts three cycles, wrap with 0001 after 1000.
    cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 0, 1);
    for (int k = 1; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001 << k, 2'(k), 0, 1);
      end
    end
    cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 1, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 0, 1);

    // dwell=0: advance every edge; load at cur_sel=3 beats the wrap.
    cyc(0, 1, 1, 0, 2'd0, 8'd0, 4'b0010, 2'd1, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd0, 4'b0100, 2'd2, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd0, 4'b1000, 2'd3, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd0, 4'b0001, 2'd0, 1, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd0, 4'b0010, 2'd1, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd0, 4'b0100, 2'd2, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd0, 4'b1000, 2'd3, 0, 1);
    cyc(0, 1, 1, 1, 2'd2, 8'd0, 4'b0100, 2'd2, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd0, 4'b1000, 2'd3, 0, 1);

    // dwell=5 from cur_sel=1, shrink to 1 after four counts: advance at once.
    cyc(0, 1, 1, 1, 2'd1, 8'd5, 4'b0010, 2'd1, 0, 1);
    for (int j = 0; j < 4; j++) begin
      cyc(0, 1, 1, 0, 2'd0, 8'd5, 4'b0010, 2'd1, 0, 1);
    end
    cyc(0, 1, 1, 0, 2'd0, 8'd1, 4'b0100, 2'd2, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd1, 4'b0100, 2'd2, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd1, 4'b1000, 2'd3, 0, 1);

    // en low three cycles (load ignored), resume at held index with full dwell.
    cyc(0, 0, 1, 0, 2'd0, 8'd2, 4'b0000, 2'd3, 0, 0);
    cyc(0, 0, 1, 1, 2'd0, 8'd2, 4'b0000, 2'd3, 0, 0);
    cyc(0, 0, 1, 0, 2'd0, 8'd2, 4'b0000, 2'd3, 0, 0);
    cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b1000, 2'd3, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b1000, 2'd3, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b1000, 2'd3, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 1, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b0001, 2'd0, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd2, 4'b0010, 2'd1, 0, 1);

    // Reset mid-scan, then normal entry; en+load together from IDLE.
    cyc(1, 1, 1, 0, 2'd0, 8'd0, 4'b0000, 2'd0, 0, 0);
    cyc(0, 1, 1, 0, 2'd0, 8'd0, 4'b0001, 2'd0, 0, 1);
    cyc(0, 1, 1, 0, 2'd0, 8'd0, 4'b0010, 2'd1, 0, 1);
    cyc(0, 0, 0, 0, 2'd0, 8'd0, 4'b0000, 2'd1, 0, 0);
    cyc(0, 1, 0, 1, 2'd2, 8'd0, 4'b0100, 2'd2, 0, 1);
    cyc(0, 1, 1, 1, 2'd3, 8'd0, 4'b1000, 2'd3, 0, 1);

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
